sc_point_matrix: RTL and testbench
==================================

Name: sc_point_matrix

Overview:
Datapath stage directly downstream of the point (frog) control state machine. It consumes that FSM's active-low load strobes and 2-bit shift selection, and holds the frog position as a row index plus a one-hot column register. It drives the flattened playfield matrix to the display/collision logic. It returns the first-row flag that the FSM uses to block "down" moves, and also a last-row (goal) flag.

Parameters:
DATAWIDTH, 8, columns per row (width of the one-hot column register)
ROWS, 8, number of rows in the playfield
INIT_ROW, 0, row loaded on reset/clear
INIT_COLUMN, 3, bit index set in the column register on reset/clear

Ports:
SC_STATEMACHINEPOINT_CLOCK_50  in  1  system clock, 50 MHz
SC_STATEMACHINEPOINT_RESET_InHigh  in  1  asynchronous active-high reset
SC_POINTMATRIX_load0_InLow  in  1  move down one row (active low)
SC_POINTMATRIX_load1_InLow  in  1  move up one row (active low)
SC_POINTMATRIX_shiftselection_In  in  2  01 = shift left, 10 = shift right, 00/11 = hold
SC_POINTMATRIX_clear_InLow  in  1  synchronous restart to initial position (active low)
SC_POINTMATRIX_matrix_Out  out  ROWS*DATAWIDTH  playfield; slice r = column if r == row, else 0
SC_POINTMATRIX_row_Out  out  $clog2(ROWS)  current row index
SC_POINTMATRIX_column_Out  out  DATAWIDTH  one-hot column register
SC_POINTMATRIX_firstreg_OutLow  out  1  0 when row == 0; feeds FSM firstreg input
SC_POINTMATRIX_lastreg_OutLow  out  1  0 when row == ROWS-1 (goal reached)

Behaviour:
- Reset is asynchronous and active high, on SC_STATEMACHINEPOINT_RESET_InHigh. The block is clocked on the rising edge of SC_STATEMACHINEPOINT_CLOCK_50.
- Reset values (defaults):
  - row = INIT_ROW (0); column = 1 << INIT_COLUMN (8'b0000_1000).
  - firstreg_OutLow = 0; lastreg_OutLow = 1.
  - matrix: only the row-0 slice = 8'h08; all other slices 0.
- State is two registers, row and column. All outputs are decoded combinationally from these registers, with no extra pipeline stage.
- Latency: a control input sampled at edge N is visible on every output after edge N.
- Per-cycle priority, highest first:
  1. clear_InLow == 0: row = INIT_ROW, column = 1 << INIT_COLUMN.
  2. load1_InLow == 0: if row < ROWS-1 then row + 1, else hold. Column unchanged.
  3. load0_InLow == 0: if row > 0 then row - 1, else hold. Column unchanged.
  4. shiftselection == 01: if column[DATAWIDTH-1] == 0 then column << 1, else hold.
  5. shiftselection == 10: if column[0] == 0 then column >> 1, else hold.
  6. Otherwise: hold.
- Saturating only, never wraps, in both row and column. The column always has exactly one bit set.
- Simultaneous events:
  - load1 and load0 both low: load1 wins.
  - A load together with a shift: the load wins and the shift is dropped.
  - clear overrides everything.
- The FSM asserts each strobe for exactly one cycle per button press, so one press moves exactly one step. The block applies every asserted cycle; it does no edge detection.
- Down-move gating is done in the FSM via firstreg. The saturation at row 0 here is a redundant safety net.
- Reset asserted mid-operation forces the reset values immediately, independent of the clock.
- Out-of-range state (row >= ROWS, or a non-one-hot column, reachable only via corruption) recovers to the initial position on the next edge.

Decomposition:
- Shared package constants:
  - SHIFT_LEFT = 2'b01, SHIFT_RIGHT = 2'b10, SHIFT_HOLD = 2'b11.
  - ROW_W = $clog2(ROWS).
- Sub-module sc_point_column_shifter: the one-hot column register with saturating left/right shift, a hold input, a clear input and the recovery check. Top level holds the row counter, priority logic and matrix decode.

Test Plan:
1. Apply reset, then release -> row = 0, column = 8'h08, firstreg_OutLow = 0, lastreg_OutLow = 1, matrix[7:0] = 8'h08, all other bits 0.
2. Pulse load1 low for 1 cycle, 3 separate times -> row = 3, firstreg = 1, matrix[31:24] = 8'h08. Then load1 held low for 10 cycles -> row saturates at 7 and lastreg_OutLow = 0.
3. At row 0, pulse load0 low -> row stays 0. At row 2, pulse load0 -> row = 1 after exactly one edge.
4. Shiftselection = 01 for 5 cycles from column 8'h08 -> 10, 20, 40, 80, 80 (saturated). Then 10 for 8 cycles -> ends at 8'h01 and holds.
5. Same cycle load1 = 0 and shiftselection = 01 -> row + 1, column unchanged. load0 = 0 and load1 = 0 together -> row + 1.
6. At row 5, column 8'h40: pulse clear_InLow -> row 0, column 8'h08. Repeat, but assert reset asynchronously mid-cycle -> outputs return to reset values before the next clock edge.

Source files
------------

// File: rtl/sc_point_matrix_pkg.sv
// Shared constants for the frog position datapath.
// Shift encodings match the point control FSM.
package sc_point_matrix_pkg;

    localparam int ROWS_DEFAULT      = 8;
    localparam int DATAWIDTH_DEFAULT = 8;
    localparam int ROW_W             = $clog2(ROWS_DEFAULT);

    localparam logic [1:0] SHIFT_NONE  = 2'b00;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;
    localparam logic [1:0] SHIFT_HOLD  = 2'b11;

endpackage

// File: rtl/sc_point_matrix_column_shifter.sv
// One-hot column register with saturating left/right shift.
// A corrupted (non one-hot) value is flagged and reloaded on the next edge.
module sc_point_column_shifter
    import sc_point_matrix_pkg::*;
#(
    parameter int DATAWIDTH   = DATAWIDTH_DEFAULT,
    parameter int INIT_COLUMN = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 hold,
    input  logic [1:0]           shift,
    output logic [DATAWIDTH-1:0] column,
    output logic                 invalid
);

    localparam logic [DATAWIDTH-1:0] ONE      = DATAWIDTH'(1);
    localparam logic [DATAWIDTH-1:0] INIT_COL = ONE << INIT_COLUMN;

    // One-hot check: exactly one bit set
    assign invalid = (column == '0) || ((column & (column - ONE)) != '0);

    // Column register: clear/recovery, then hold, then saturating shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            column <= INIT_COL;
        end else if (clear || invalid) begin
            column <= INIT_COL;
        end else if (!hold) begin
            case (shift)
                SHIFT_LEFT: begin
                    if (!column[DATAWIDTH-1]) column <= column << 1;
                end
                SHIFT_RIGHT: begin
                    if (!column[0]) column <= column >> 1;
                end
                default: column <= column;
            endcase
        end
    end

endmodule

// File: rtl/sc_point_matrix.sv
// Frog position datapath: row counter, column shifter and playfield decode.
// Row moves take priority over column shifts; clear overrides both.
module sc_point_matrix
    import sc_point_matrix_pkg::*;
#(
    parameter int DATAWIDTH   = DATAWIDTH_DEFAULT,
    parameter int ROWS        = ROWS_DEFAULT,
    parameter int INIT_ROW    = 0,
    parameter int INIT_COLUMN = 3
) (
    input  logic                      SC_STATEMACHINEPOINT_CLOCK_50,
    input  logic                      SC_STATEMACHINEPOINT_RESET_InHigh,
    input  logic                      SC_POINTMATRIX_load0_InLow,
    input  logic                      SC_POINTMATRIX_load1_InLow,
    input  logic [1:0]                SC_POINTMATRIX_shiftselection_In,
    input  logic                      SC_POINTMATRIX_clear_InLow,
    output logic [ROWS*DATAWIDTH-1:0] SC_POINTMATRIX_matrix_Out,
    output logic [$clog2(ROWS)-1:0]   SC_POINTMATRIX_row_Out,
    output logic [DATAWIDTH-1:0]      SC_POINTMATRIX_column_Out,
    output logic                      SC_POINTMATRIX_firstreg_OutLow,
    output logic                      SC_POINTMATRIX_lastreg_OutLow
);

    localparam int RW = $clog2(ROWS);
    localparam logic [RW-1:0] ROW_INIT = RW'(INIT_ROW);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW:0]   ROW_LIM  = (RW + 1)'(ROWS);

    logic [RW-1:0]        row;
    logic [DATAWIDTH-1:0] column;
    logic                 col_bad;
    logic                 row_bad;
    logic                 restart;
    logic                 load_any;

    assign row_bad  = {1'b0, row} >= ROW_LIM;
    assign restart  = !SC_POINTMATRIX_clear_InLow || row_bad || col_bad;
    assign load_any = !SC_POINTMATRIX_load1_InLow
                   || !SC_POINTMATRIX_load0_InLow;

    // Row counter: restart, then up (load1), then down (load0), saturating
    always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50
                or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
        if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
            row <= ROW_INIT;
        end else if (restart) begin
            row <= ROW_INIT;
        end else if (!SC_POINTMATRIX_load1_InLow) begin
            if (row < ROW_LAST) row <= row + ROW_ONE;
        end else if (!SC_POINTMATRIX_load0_InLow) begin
            if (row != '0) row <= row - ROW_ONE;
        end
    end

    sc_point_column_shifter #(
        .DATAWIDTH   (DATAWIDTH),
        .INIT_COLUMN (INIT_COLUMN)
    ) u_column (
        .clk     (SC_STATEMACHINEPOINT_CLOCK_50),
        .rst     (SC_STATEMACHINEPOINT_RESET_InHigh),
        .clear   (restart),
        .hold    (load_any),
        .shift   (SC_POINTMATRIX_shiftselection_In),
        .column  (column),
        .invalid (col_bad)
    );

    // Playfield decode: only the current row slice carries the column
    for (genvar g = 0; g < ROWS; g++) begin : g_rows
        assign SC_POINTMATRIX_matrix_Out[g*DATAWIDTH +: DATAWIDTH] =
            (row == RW'(g)) ? column : '0;
    end

    assign SC_POINTMATRIX_row_Out         = row;
    assign SC_POINTMATRIX_column_Out      = column;
    assign SC_POINTMATRIX_firstreg_OutLow = (row != '0);
    assign SC_POINTMATRIX_lastreg_OutLow  = (row != ROW_LAST);

endmodule

// File: tb/tb_sc_point_matrix.sv
// Directed bench for sc_point_matrix.
// Expected values are hand computed for the default 8x8 playfield.
module tb_sc_point_matrix;

    logic        clk;
    logic        rst;
    logic        load0_n;
    logic        load1_n;
    logic [1:0]  shsel;
    logic        clear_n;
    logic [63:0] matrix;
    logic [2:0]  row;
    logic [7:0]  column;
    logic        first_n;
    logic        last_n;

    int passed = 0;
    int total  = 0;

    sc_point_matrix dut (
        .SC_STATEMACHINEPOINT_CLOCK_50     (clk),
        .SC_STATEMACHINEPOINT_RESET_InHigh (rst),
        .SC_POINTMATRIX_load0_InLow        (load0_n),
        .SC_POINTMATRIX_load1_InLow        (load1_n),
        .SC_POINTMATRIX_shiftselection_In  (shsel),
        .SC_POINTMATRIX_clear_InLow        (clear_n),
        .SC_POINTMATRIX_matrix_Out         (matrix),
        .SC_POINTMATRIX_row_Out            (row),
        .SC_POINTMATRIX_column_Out         (column),
        .SC_POINTMATRIX_firstreg_OutLow    (first_n),
        .SC_POINTMATRIX_lastreg_OutLow     (last_n)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1;
        load0_n = 1'b1;
        load1_n = 1'b1;
        shsel = 2'b00;
        clear_n = 1'b1;
        steps(2);
        rst = 1'b0;

        // 1: reset state
        chk("rst_row", row, 0);
        chk("rst_col", column, 8'h08);
        chk("rst_first", first_n, 0);
        chk("rst_last", last_n, 1);
        chk("rst_matrix", matrix, 64'h08);
        step();
        chk("idle_row", row, 0);

        // 2: single-cycle up pulses, then saturation
        load1_n = 1'b0; step(); load1_n = 1'b1;
        chk("up1_row", row, 1);
        step();
        load1_n = 1'b0; step(); load1_n = 1'b1; step();
        load1_n = 1'b0; step(); load1_n = 1'b1; step();
        chk("up3_row", row, 3);
        chk("up3_first", first_n, 1);
        chk("up3_matrix", matrix, 64'h0000_0000_0800_0000);
        load1_n = 1'b0; steps(10); load1_n = 1'b1;
        chk("sat_row", row, 7);
        chk("sat_last", last_n, 0);
        chk("sat_matrix", matrix, 64'h0800_0000_0000_0000);

        // 3: down moves and floor saturation
        load0_n = 1'b0; steps(7); load0_n = 1'b1;
        chk("down_row", row, 0);
        load0_n = 1'b0; step(); load0_n = 1'b1;
        chk("floor_row", row, 0);
        chk("floor_first", first_n, 0);
        load1_n = 1'b0; steps(2); load1_n = 1'b1;
        chk("up2_row", row, 2);
        load0_n = 1'b0; step(); load0_n = 1'b1;
        chk("down1_row", row, 1);

        // 4: column shifts with saturation
        shsel = 2'b01;
        step(); chk("shl1", column, 8'h10);
        step(); chk("shl2", column, 8'h20);
        step(); chk("shl3", column, 8'h40);
        step(); chk("shl4", column, 8'h80);
        step(); chk("shl5", column, 8'h80);
        shsel = 2'b10;
        step(); chk("shr1", column, 8'h40);
        steps(7); chk("shr8", column, 8'h01);
        step(); chk("shr_sat", column, 8'h01);
        shsel = 2'b11;
        step(); chk("hold11", column, 8'h01);
        chk("hold_matrix", matrix, 64'h0000_0000_0000_0100);

        // 5: simultaneous events
        load1_n = 1'b0; shsel = 2'b01; step();
        load1_n = 1'b1; shsel = 2'b00;
        chk("ld_sh_row", row, 2);
        chk("ld_sh_col", column, 8'h01);
        load1_n = 1'b0; load0_n = 1'b0; step();
        load1_n = 1'b1; load0_n = 1'b1;
        chk("both_row", row, 3);

        // 6: clear from row 5, column 0x40
        load1_n = 1'b0; steps(2); load1_n = 1'b1;
        shsel = 2'b01; steps(6); shsel = 2'b00;
        chk("pre_clr_row", row, 5);
        chk("pre_clr_col", column, 8'h40);
        clear_n = 1'b0; load1_n = 1'b0; step();
        clear_n = 1'b1; load1_n = 1'b1;
        chk("clr_row", row, 0);
        chk("clr_col", column, 8'h08);
        chk("clr_matrix", matrix, 64'h08);

        // async reset mid-cycle
        load1_n = 1'b0; steps(5); load1_n = 1'b1;
        shsel = 2'b01; steps(3); shsel = 2'b00;
        chk("pre_rst_row", row, 5);
        chk("pre_rst_col", column, 8'h40);
        #5 rst = 1'b1;
        #1;
        chk("arst_row", row, 0);
        chk("arst_col", column, 8'h08);
        chk("arst_first", first_n, 0);
        chk("arst_last", last_n, 1);
        chk("arst_matrix", matrix, 64'h08);
        #2 rst = 1'b0;
        step();
        chk("post_rst_row", row, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
